// File: rtl/text_char_buffer.sv
// Character screen for the text overlay: byte-stream writer with terminal-style cursor
// handling and hardware scroll, plus a pixel-addressed read port feeding the glyph renderer.
module text_char_buffer #(
   parameter int COLS = 32,
   parameter int ROWS = 4,
   parameter int X0   = 192,
   parameter int Y0   = 208
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic [6:0] ascii_code,
   output logic [4:0] cursor_col,
   output logic [1:0] cursor_row
);

   localparam int         CELLS      = COLS * ROWS;
   localparam logic [6:0] SPACE      = 7'h20;
   localparam logic [4:0] LAST_COL   = 5'(COLS - 1);
   localparam logic [1:0] LAST_ROW   = 2'(ROWS - 1);
   localparam logic [6:0] LAST_CELL  = 7'(CELLS - 1);
   localparam logic [6:0] LAST_DST   = 7'(CELLS - COLS - 1);
   localparam logic [6:0] ROW_STRIDE = 7'(COLS);
   localparam logic [7:0] CH_BS      = 8'h08;
   localparam logic [7:0] CH_LF      = 8'h0A;
   localparam logic [7:0] CH_FF      = 8'h0C;
   localparam logic [7:0] CH_CR      = 8'h0D;

   typedef enum logic [2:0] {CLEAR, IDLE, SCROLL_RD, SCROLL_WR, SCROLL_CLR} state_t;

   state_t     state;
   logic [6:0] cnt;
   logic [6:0] mem [CELLS];

   logic       accept, printable;
   logic       b_we;
   logic [6:0] b_addr, b_wdata, b_rd_addr, b_rdata;
   logic [6:0] a_addr, a_rdata;
   logic [9:0] dx, dy;
   logic       in_win, in_win_q;
   logic       unused_bits;

   assign accept    = wr_valid & wr_ready;
   assign printable = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
   assign b_rd_addr = cnt + ROW_STRIDE;

   // Write-engine port: a single write per cycle, chosen by state and the accepted byte
   always_comb begin
      b_we    = 1'b0;
      b_addr  = cnt;
      b_wdata = SPACE;
      case (state)
         CLEAR, SCROLL_CLR: b_we = 1'b1;
         SCROLL_WR: begin
            b_we    = 1'b1;
            b_wdata = b_rdata;
         end
         IDLE: begin
            if (accept && printable) begin
               b_we    = 1'b1;
               b_addr  = {cursor_row, cursor_col};
               b_wdata = wr_data[6:0];
            end else if (accept && wr_data == CH_BS) begin
               if (cursor_col != 5'd0) begin
                  b_we   = 1'b1;
                  b_addr = {cursor_row, cursor_col - 5'd1};
               end else if (cursor_row != 2'd0) begin
                  b_we   = 1'b1;
                  b_addr = {cursor_row - 2'd1, LAST_COL};
               end
            end
         end
         default: b_we = 1'b0;
      endcase
   end

   // Both reads sample before the write lands, so port A sees old data on a collision
   always_ff @(posedge clk) begin
      if (b_we) mem[b_addr] <= b_wdata;
      a_rdata <= mem[a_addr];
      b_rdata <= mem[b_rd_addr];
   end

   assign dx     = x - 10'(X0);
   assign dy     = y - 10'(Y0);
   assign in_win = (x >= 10'(X0)) && (x < 10'(X0 + COLS * 8)) &&
                   (y >= 10'(Y0)) && (y < 10'(Y0 + ROWS * 16));
   assign a_addr = {dy[5:4], dx[7:3]};
   assign unused_bits = ^{dx[9:8], dx[2:0], dy[9:6], dy[3:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_win_q <= 1'b0;
      else          in_win_q <= in_win;
   end

   assign ascii_code = in_win_q ? a_rdata : SPACE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLEAR;
         cnt        <= 7'd0;
         cursor_col <= 5'd0;
         cursor_row <= 2'd0;
         wr_ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               cnt <= cnt + 7'd1;
               if (cnt == LAST_CELL) begin
                  state      <= IDLE;
                  cursor_col <= 5'd0;
                  cursor_row <= 2'd0;
                  wr_ready   <= 1'b1;
               end
            end
            IDLE: begin
               if (accept) begin
                  if (printable) begin
                     if (cursor_col != LAST_COL) begin
                        cursor_col <= cursor_col + 5'd1;
                     end else begin
                        cursor_col <= 5'd0;
                        if (cursor_row != LAST_ROW) begin
                           cursor_row <= cursor_row + 2'd1;
                        end else begin
                           state    <= SCROLL_RD;
                           cnt      <= 7'd0;
                           wr_ready <= 1'b0;
                        end
                     end
                  end else begin
                     case (wr_data)
                        CH_CR: cursor_col <= 5'd0;
                        CH_LF: begin
                           cursor_col <= 5'd0;
                           if (cursor_row != LAST_ROW) begin
                              cursor_row <= cursor_row + 2'd1;
                           end else begin
                              state    <= SCROLL_RD;
                              cnt      <= 7'd0;
                              wr_ready <= 1'b0;
                           end
                        end
                        CH_BS: begin
                           if (cursor_col != 5'd0) begin
                              cursor_col <= cursor_col - 5'd1;
                           end else if (cursor_row != 2'd0) begin
                              cursor_col <= LAST_COL;
                              cursor_row <= cursor_row - 2'd1;
                           end
                        end
                        CH_FF: begin
                           state    <= CLEAR;
                           cnt      <= 7'd0;
                           wr_ready <= 1'b0;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            SCROLL_RD: state <= SCROLL_WR;
            SCROLL_WR: begin
               cnt   <= cnt + 7'd1;
               state <= (cnt == LAST_DST) ? SCROLL_CLR : SCROLL_RD;
            end
            SCROLL_CLR: begin
               cnt <= cnt + 7'd1;
               if (cnt == LAST_CELL) begin
                  state    <= IDLE;
                  wr_ready <= 1'b1;
               end
            end
            default: begin
               state    <= CLEAR;
               cnt      <= 7'd0;
               wr_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_char_buffer.sv
// Bench for text_char_buffer: screen-level model of the terminal, a per-cycle compare
// process for cursor and pixel reads while idle, and directed vectors with literal expectations.
module tb_text_char_buffer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_ready;
   logic [9:0] x = 10'd0;
   logic [9:0] y = 10'd0;
   logic [6:0] ascii_code;
   logic [4:0] cursor_col;
   logic [1:0] cursor_row;

   int checks = 0;
   int failures = 0;
   int last_waits = 0;

   logic [6:0] scr [4][32];
   int m_col = 0;
   int m_row = 0;

   text_char_buffer dut (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .x(x), .y(y), .ascii_code(ascii_code),
      .cursor_col(cursor_col), .cursor_row(cursor_row)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- screen model ----------------
   task automatic m_clear();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 32; c++) scr[r][c] = 7'h20;
      m_col = 0;
      m_row = 0;
   endtask

   task automatic m_scroll();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 32; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < 32; c++) scr[3][c] = 7'h20;
   endtask

   task automatic m_apply(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         scr[m_row][m_col] = b[6:0];
         if (m_col < 31) m_col++;
         else begin
            m_col = 0;
            if (m_row < 3) m_row++;
            else m_scroll();
         end
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h0A) begin
         m_col = 0;
         if (m_row < 3) m_row++;
         else m_scroll();
      end else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
            scr[m_row][m_col] = 7'h20;
         end else if (m_row > 0) begin
            m_row--;
            m_col = 31;
            scr[m_row][m_col] = 7'h20;
         end
      end else if (b == 8'h0C) begin
         m_clear();
      end
   endtask

   function automatic logic [6:0] m_pixel(input int px, input int py);
      if (px >= 192 && px < 448 && py >= 208 && py < 272)
         return scr[(py - 208) / 16][(px - 192) / 8];
      return 7'h20;
   endfunction

   // ---------------- per-cycle compare while the writer is idle ----------------
   logic [6:0] pend_exp;
   bit         pend = 1'b0;
   always @(negedge clk) begin
      if (reset_n && pend) check("ascii_stream", ascii_code, pend_exp);
      pend = 1'b0;
      if (reset_n && wr_ready) begin
         check("cursor_col_stream", cursor_col, m_col);
         check("cursor_row_stream", cursor_row, m_row);
         pend_exp = m_pixel(int'(x), int'(y));
         pend = 1'b1;
      end
   end

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic rand_xy();
      x = 10'($urandom_range(150, 470));
      y = 10'($urandom_range(190, 290));
   endtask

   task automatic sweep(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rand_xy();
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic r;
      wr_valid = 1'b1;
      wr_data  = b;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         r = wr_ready;
         @(posedge clk); #1;
         if (r) begin
            last_waits = i;
            m_apply(b);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%0h never accepted", b);
      last_waits = 600;
   endtask

   task automatic send_n(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) send(b);
   endtask

   task automatic wait_ready(input int exp, input string name);
      int n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (wr_ready) break;
         n++;
         @(posedge clk); #1;
         rand_xy();
      end
      @(posedge clk); #1;
      check(name, n, exp);
   endtask

   task automatic read_px(input int px, input int py, input logic [6:0] exp, input string name);
      x = 10'(px);
      y = 10'(py);
      @(posedge clk); #1;
      check(name, ascii_code, exp);
   endtask

   task automatic check_cursor(input int col, input int row, input string name);
      check({name, "_col"}, cursor_col, col);
      check({name, "_row"}, cursor_row, row);
   endtask

   task automatic ff_clear(input string name);
      send(8'h0C);
      wr_valid = 1'b0;
      wait_ready(128, name);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset_n = 1'b1;
      #3 reset_n = 1'b0;
      wr_valid = 1'b1;
      wr_data  = 8'h00;
      x = 10'd300;
      y = 10'd240;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_ready", wr_ready, 0);
      check("rst_ascii", ascii_code, 7'h20);
      check_cursor(0, 0, "rst_cursor");
      m_clear();
      reset_n = 1'b1;
      wait_ready(128, "clear_len_after_reset");
      wr_valid = 1'b0;
      read_px(300, 240, 7'h20, "blank_after_clear");
      check_cursor(0, 0, "cursor_after_clear");
      sweep(20);

      // "AB" back to back
      send(8'h41);
      check("A_waits", last_waits, 0);
      send(8'h42);
      check("B_waits", last_waits, 0);
      wr_valid = 1'b0;
      check_cursor(2, 0, "cursor_AB");
      read_px(192, 208, 7'h41, "px_A");
      read_px(200, 208, 7'h42, "px_B");
      read_px(100, 100, 7'h20, "px_outside");

      // full row of X wraps to next row
      ff_clear("ff_len_1");
      send_n(8'h58, 32);
      wr_valid = 1'b0;
      check_cursor(0, 1, "cursor_row_wrap");
      read_px(440, 208, 7'h58, "px_X_col31");
      read_px(447, 208, 7'h58, "px_right_edge");
      read_px(448, 208, 7'h20, "px_past_right");
      read_px(191, 208, 7'h20, "px_before_left");
      read_px(192, 207, 7'h20, "px_above_top");
      sweep(30);

      // LF at row 3 scrolls
      ff_clear("ff_len_2");
      send_n(8'h51, 32);
      send_n(8'h4D, 32);
      send(8'h0A);
      send_n(8'h5A, 31);
      wr_valid = 1'b0;
      check_cursor(31, 3, "cursor_before_lf");
      send(8'h0A);
      wr_valid = 1'b0;
      wait_ready(224, "scroll_lf_len");
      check_cursor(0, 3, "cursor_after_lf_scroll");
      read_px(192, 208, 7'h4D, "scroll_row0_from_row1");
      read_px(192, 224, 7'h20, "scroll_row1_from_row2");
      read_px(432, 240, 7'h5A, "scroll_row2_Z");
      read_px(440, 240, 7'h20, "scroll_row2_col31");
      read_px(447, 271, 7'h20, "scroll_row3_blank");
      sweep(30);

      // printable at (31,3) scrolls
      send_n(8'h4B, 31);
      send(8'h4B);
      wr_valid = 1'b0;
      wait_ready(224, "scroll_wrap_len");
      check_cursor(0, 3, "cursor_after_wrap_scroll");
      read_px(440, 240, 7'h4B, "wrap_row2_col31");
      read_px(192, 224, 7'h5A, "wrap_row1_Z");
      read_px(440, 256, 7'h20, "wrap_row3_blank");

      // backspace
      ff_clear("ff_len_3");
      send_n(8'h50, 64);
      wr_valid = 1'b0;
      check_cursor(0, 2, "cursor_before_bs");
      send(8'h08);
      wr_valid = 1'b0;
      check_cursor(31, 1, "cursor_bs_wrap");
      read_px(440, 224, 7'h20, "bs_cell63");
      read_px(432, 224, 7'h50, "bs_cell62_kept");
      send(8'h08);
      wr_valid = 1'b0;
      check_cursor(30, 1, "cursor_bs_mid");
      read_px(432, 224, 7'h20, "bs_cell62");
      ff_clear("ff_len_4");
      send(8'h41);
      send(8'h08);
      wr_valid = 1'b0;
      read_px(192, 208, 7'h20, "bs_cell0");
      send(8'h08);
      check("bs_origin_waits", last_waits, 0);
      send(8'h07);
      check("bel_waits", last_waits, 0);
      send(8'hC1);
      check("hibit_waits", last_waits, 0);
      wr_valid = 1'b0;
      check_cursor(0, 0, "cursor_noops");
      read_px(192, 208, 7'h20, "noop_cell0");
      read_px(447, 271, 7'h20, "noop_cell127");

      // CR
      send(8'h48);
      send(8'h49);
      send(8'h0D);
      wr_valid = 1'b0;
      check_cursor(0, 0, "cursor_cr");
      send(8'h4A);
      wr_valid = 1'b0;
      read_px(192, 208, 7'h4A, "cr_overwrite");
      read_px(200, 208, 7'h49, "cr_kept");

      // FF with data on screen
      ff_clear("ff_len_5");
      check_cursor(0, 0, "cursor_after_ff");
      read_px(192, 208, 7'h20, "ff_cell0");
      read_px(200, 208, 7'h20, "ff_cell1");
      sweep(20);

      // reset during a scroll
      send_n(8'h0A, 3);
      send_n(8'h59, 5);
      send(8'h0A);
      wr_valid = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
      end
      x = 10'd192;
      y = 10'd208;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("midrst_wr_ready", wr_ready, 0);
      check("midrst_ascii", ascii_code, 7'h20);
      check_cursor(0, 0, "midrst_cursor");
      m_clear();
      @(posedge clk); #1;
      reset_n = 1'b1;
      wait_ready(128, "clear_len_after_midrst");
      read_px(192, 256, 7'h20, "midrst_row3_blank");
      read_px(232, 240, 7'h20, "midrst_row2_blank");
      sweep(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog simulation did not finish in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
